// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: 2-entry result FIFO feeding the register file write port,
// with load formatting at push and youngest-first forwarding onto the decode read path.
module wb_commit_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_regwrite,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_alu_res,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_mem_to_reg,
    input  logic [1:0]        i_ld_size,
    input  logic              i_ld_unsigned,
    input  logic [1:0]        i_byte_off,
    input  logic              i_hold,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    input  logic [DATA_W-1:0] i_rdata1,
    input  logic [DATA_W-1:0] i_rdata2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic [31:0]       o_retired
);

    logic [1:0]        count_q;
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic              ent_rw_q   [2];
    logic [ADDR_W-1:0] ent_addr_q [2];
    logic [DATA_W-1:0] ent_data_q [2];
    logic [31:0]       retired_q;

    logic              push;
    logic              pop;
    logic              head_vld;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] fmt_data;
    logic [DATA_W-1:0] push_data;

    always_comb begin
        byte_sel = i_mem_data[{i_byte_off, 3'b000} +: 8];
        half_sel = i_byte_off[1] ? i_mem_data[31:16] : i_mem_data[15:0];
        case (i_ld_size)
            2'b00:   fmt_data = {{(DATA_W-8){byte_sel[7] & ~i_ld_unsigned}}, byte_sel};
            2'b01:   fmt_data = {{(DATA_W-16){half_sel[15] & ~i_ld_unsigned}}, half_sel};
            default: fmt_data = i_mem_data;
        endcase
        push_data = i_mem_to_reg ? fmt_data : i_alu_res;
    end

    assign head_vld = (count_q != 2'd0);
    assign o_ready  = (count_q != 2'd2);
    assign push     = i_valid && o_ready;
    assign pop      = head_vld && !i_hold;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q   <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            retired_q <= 32'd0;
            for (int i = 0; i < 2; i++) begin
                ent_rw_q[i]   <= 1'b0;
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                ent_rw_q[wr_ptr_q]   <= i_regwrite;
                ent_addr_q[wr_ptr_q] <= i_waddr;
                ent_data_q[wr_ptr_q] <= push_data;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q  <= ~rd_ptr_q;
                retired_q <= retired_q + 32'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_we      = pop && ent_rw_q[rd_ptr_q] && (ent_addr_q[rd_ptr_q] != '0);
    assign o_waddr   = head_vld ? ent_addr_q[rd_ptr_q] : '0;
    assign o_wdata   = head_vld ? ent_data_q[rd_ptr_q] : '0;
    assign o_retired = retired_q;

    // The youngest entry sits just behind the write pointer; the older one only exists when full.
    logic young_idx;
    logic young_vld;
    logic old_vld;
    assign young_idx = ~wr_ptr_q;
    assign young_vld = head_vld && ent_rw_q[young_idx];
    assign old_vld   = (count_q == 2'd2) && ent_rw_q[rd_ptr_q];

    always_comb begin
        o_rdata1 = i_rdata1;
        if (i_raddr1 == '0)
            o_rdata1 = '0;
        else if (young_vld && ent_addr_q[young_idx] == i_raddr1)
            o_rdata1 = ent_data_q[young_idx];
        else if (old_vld && ent_addr_q[rd_ptr_q] == i_raddr1)
            o_rdata1 = ent_data_q[rd_ptr_q];
    end

    always_comb begin
        o_rdata2 = i_rdata2;
        if (i_raddr2 == '0)
            o_rdata2 = '0;
        else if (young_vld && ent_addr_q[young_idx] == i_raddr2)
            o_rdata2 = ent_data_q[young_idx];
        else if (old_vld && ent_addr_q[rd_ptr_q] == i_raddr2)
            o_rdata2 = ent_data_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Testbench for wb_commit_stage: directed scenarios plus a randomized run against a
// queue-based reference model with its own register file.
module tb_wb_commit_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic        i_regwrite;
    logic [4:0]  i_waddr;
    logic [31:0] i_alu_res;
    logic [31:0] i_mem_data;
    logic        i_mem_to_reg;
    logic [1:0]  i_ld_size;
    logic        i_ld_unsigned;
    logic [1:0]  i_byte_off;
    logic        i_hold;
    logic        o_we;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [4:0]  i_raddr1, i_raddr2;
    logic [31:0] i_rdata1, i_rdata2;
    logic [31:0] o_rdata1, o_rdata2;
    logic [31:0] o_retired;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_ret;

    always #5 i_clk = ~i_clk;

    wb_commit_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_regwrite(i_regwrite), .i_waddr(i_waddr), .i_alu_res(i_alu_res),
        .i_mem_data(i_mem_data), .i_mem_to_reg(i_mem_to_reg), .i_ld_size(i_ld_size),
        .i_ld_unsigned(i_ld_unsigned), .i_byte_off(i_byte_off), .i_hold(i_hold),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .i_raddr1(i_raddr1), .i_raddr2(i_raddr2), .i_rdata1(i_rdata1), .i_rdata2(i_rdata2),
        .o_rdata1(o_rdata1), .o_rdata2(o_rdata2), .o_retired(o_retired)
    );

    typedef struct packed {
        logic        rw;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] rf[32];

    function automatic logic [31:0] ref_fmt(input logic [31:0] mem, input logic [1:0] size,
                                            input logic uns, input logic [1:0] off,
                                            input logic m2r, input logic [31:0] alu);
        logic [31:0] v;
        if (!m2r) return alu;
        if (size == 2'd0) begin
            v = (mem >> (off * 8)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (size == 2'd1) begin
            v = (mem >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_byp(input logic [4:0] ra, input logic [31:0] rd);
        if (ra == 0) return 32'd0;
        for (int k = mq.size() - 1; k >= 0; k--)
            if (mq[k].rw && mq[k].a == ra) return mq[k].d;
        return rd;
    endfunction

    task automatic idle_inputs();
        i_valid = 0; i_regwrite = 0; i_waddr = 0; i_alu_res = 0; i_mem_data = 0;
        i_mem_to_reg = 0; i_ld_size = 0; i_ld_unsigned = 0; i_byte_off = 0; i_hold = 0;
        i_raddr1 = 0; i_raddr2 = 0; i_rdata1 = 0; i_rdata2 = 0;
    endtask

    task automatic push_alu(input logic [4:0] a, input logic [31:0] d);
        i_valid = 1; i_regwrite = 1; i_waddr = a; i_alu_res = d; i_mem_to_reg = 0;
    endtask

    task automatic test_reset();
        i_rst = 1;
        idle_inputs();
        @(posedge i_clk); @(posedge i_clk); @(negedge i_clk); #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", o_ready); end
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", o_we); end
        n_checks++; if (o_waddr !== 5'd0 || o_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_wport got %h/%h exp 0/0", o_waddr, o_wdata); end
        n_checks++; if (o_retired !== 32'd0) begin n_fail++; $display("FAIL rst_retired got %h exp 0", o_retired); end
        i_rst = 0;
        push_alu(5'd7, 32'hA1A1_0001);
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 0; #1;
        n_checks++; if (o_we !== 1'b1 || o_waddr !== 5'd7 || o_wdata !== 32'hA1A1_0001) begin n_fail++; $display("FAIL first_write got %b/%h/%h exp 1/07/a1a10001", o_we, o_waddr, o_wdata); end
        @(posedge i_clk); @(negedge i_clk);
        n_checks++; if (o_retired !== 32'd1) begin n_fail++; $display("FAIL first_retire got %h exp 1", o_retired); end
        i_hold = 1; push_alu(5'd8, 32'hB0);
        @(posedge i_clk); @(negedge i_clk);
        push_alu(5'd9, 32'hB1);
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 0; #1;
        n_checks++; if (o_ready !== 1'b0 || o_we !== 1'b0) begin n_fail++; $display("FAIL held_full got ready=%b we=%b exp 0/0", o_ready, o_we); end
        i_rst = 1; #1;
        n_checks++; if (o_we !== 1'b0 || o_ready !== 1'b1 || o_retired !== 32'd0) begin n_fail++; $display("FAIL midrst got we=%b ready=%b ret=%h exp 0/1/0", o_we, o_ready, o_retired); end
        @(posedge i_clk); @(negedge i_clk);
        i_rst = 0; i_hold = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (o_we !== 1'b0 || o_retired !== 32'd0) begin n_fail++; $display("FAIL post_rst_write c=%0d got we=%b ret=%h exp 0/0", c, o_we, o_retired); end
            @(posedge i_clk); @(negedge i_clk);
        end
        exp_ret = 0;
    endtask

    task automatic test_load_format();
        logic [37:0] tbl[7];
        logic [37:0] t;
        // {size, unsigned, off, expected}
        tbl[0] = {2'b00, 1'b0, 2'd1, 1'b0, 32'h0000_007F};
        tbl[1] = {2'b00, 1'b0, 2'd3, 1'b0, 32'hFFFF_FF80};
        tbl[2] = {2'b00, 1'b1, 2'd3, 1'b0, 32'h0000_0080};
        tbl[3] = {2'b01, 1'b0, 2'd2, 1'b0, 32'hFFFF_8081};
        tbl[4] = {2'b10, 1'b0, 2'd1, 1'b0, 32'h8081_7F02};
        tbl[5] = {2'b01, 1'b1, 2'd1, 1'b0, 32'h0000_7F02};
        tbl[6] = {2'b11, 1'b0, 2'd2, 1'b0, 32'h8081_7F02};
        for (int i = 0; i < 7; i++) begin
            t = tbl[i];
            i_valid = 1; i_regwrite = 1; i_waddr = 5'd10; i_alu_res = 32'h5555_5555;
            i_mem_data = 32'h8081_7F02; i_mem_to_reg = 1;
            i_ld_size = t[37:36]; i_ld_unsigned = t[35]; i_byte_off = t[34:33];
            @(posedge i_clk); @(negedge i_clk);
            i_valid = 0; #1;
            n_checks++; if (o_we !== 1'b1 || o_wdata !== t[31:0]) begin n_fail++; $display("FAIL load_fmt case %0d got we=%b data=%h exp 1/%h", i, o_we, o_wdata, t[31:0]); end
            @(posedge i_clk); @(negedge i_clk);
            exp_ret++;
        end
        i_mem_to_reg = 0;
    endtask

    task automatic test_zero_write();
        push_alu(5'd0, 32'h1234);
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 0; i_raddr1 = 0; i_rdata1 = 32'hDEAD_BEEF; #1;
        n_checks++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL zero_we got %b exp 0", o_we); end
        n_checks++; if (o_rdata1 !== 32'd0) begin n_fail++; $display("FAIL zero_byp got %h exp 0", o_rdata1); end
        @(posedge i_clk); @(negedge i_clk);
        exp_ret++;
        n_checks++; if (o_retired !== exp_ret) begin n_fail++; $display("FAIL zero_retire got %h exp %h", o_retired, exp_ret); end
    endtask

    task automatic test_back_to_back();
        i_hold = 1;
        push_alu(5'd5, 32'h11);
        @(posedge i_clk); @(negedge i_clk);
        push_alu(5'd5, 32'h22);
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 0; i_raddr1 = 5; i_rdata1 = 32'hAAAA; i_raddr2 = 5; i_rdata2 = 32'hBBBB; #1;
        n_checks++; if (o_ready !== 1'b0 || o_we !== 1'b0) begin n_fail++; $display("FAIL b2b_full got ready=%b we=%b exp 0/0", o_ready, o_we); end
        n_checks++; if (o_rdata1 !== 32'h22 || o_rdata2 !== 32'h22) begin n_fail++; $display("FAIL b2b_youngest got %h/%h exp 22/22", o_rdata1, o_rdata2); end
        i_hold = 0; #1;
        n_checks++; if (o_we !== 1'b1 || o_waddr !== 5'd5 || o_wdata !== 32'h11 || o_rdata1 !== 32'h22) begin n_fail++; $display("FAIL b2b_w1 got %b/%h/%h byp %h exp 1/05/11 byp 22", o_we, o_waddr, o_wdata, o_rdata1); end
        @(posedge i_clk); @(negedge i_clk); #1;
        n_checks++; if (o_we !== 1'b1 || o_wdata !== 32'h22 || o_rdata1 !== 32'h22 || o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_w2 got %b/%h byp %h rdy %b exp 1/22 byp 22 rdy 1", o_we, o_wdata, o_rdata1, o_ready); end
        @(posedge i_clk); @(negedge i_clk); #1;
        n_checks++; if (o_we !== 1'b0 || o_rdata1 !== 32'hAAAA) begin n_fail++; $display("FAIL b2b_drain got we=%b byp %h exp 0/aaaa", o_we, o_rdata1); end
        exp_ret += 2;
        n_checks++; if (o_retired !== exp_ret) begin n_fail++; $display("FAIL b2b_retire got %h exp %h", o_retired, exp_ret); end
        i_raddr1 = 0; i_raddr2 = 0;
    endtask

    task automatic test_stream();
        logic [31:0] start;
        start = exp_ret;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) push_alu(5'(i + 1), 32'h100 + i);
            else i_valid = 0;
            #1;
            n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready i=%0d got %b exp 1", i, o_ready); end
            if (i > 0) begin
                n_checks++;
                if (o_we !== 1'b1 || o_waddr !== 5'(i) || o_wdata !== 32'h100 + i - 1) begin
                    n_fail++; $display("FAIL stream_write i=%0d got %b/%h/%h exp 1/%h/%h", i, o_we, o_waddr, o_wdata, 5'(i), 32'h100 + i - 1);
                end
            end
            @(posedge i_clk); @(negedge i_clk);
        end
        exp_ret = start + 10;
        n_checks++; if (o_retired !== exp_ret || o_we !== 1'b0) begin n_fail++; $display("FAIL stream_end got ret=%h we=%b exp %h/0", o_retired, o_we, exp_ret); end
    endtask

    task automatic test_wrap();
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        n_checks++; if (o_retired !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got %h exp ffffffff", o_retired); end
        push_alu(5'd3, 32'h77);
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 0;
        @(posedge i_clk); @(negedge i_clk); #1;
        n_checks++; if (o_retired !== 32'd0) begin n_fail++; $display("FAIL wrap got %h exp 0", o_retired); end
        exp_ret = 0;
    endtask

    task automatic test_random();
        logic push, pop;
        ent_t e;
        logic [31:0] ev;
        for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : $urandom;
        for (int c = 0; c < 400; c++) begin
            i_valid       = ($urandom_range(0, 9) < 7);
            i_hold        = ($urandom_range(0, 3) == 0);
            i_regwrite    = ($urandom_range(0, 7) != 0);
            i_waddr       = 5'($urandom_range(0, 7));
            i_alu_res     = $urandom;
            i_mem_data    = $urandom;
            i_mem_to_reg  = $urandom_range(0, 1) == 1;
            i_ld_size     = 2'($urandom_range(0, 3));
            i_ld_unsigned = $urandom_range(0, 1) == 1;
            i_byte_off    = 2'($urandom_range(0, 3));
            i_raddr1      = 5'($urandom_range(0, 7));
            i_raddr2      = 5'($urandom_range(0, 7));
            i_rdata1      = rf[i_raddr1];
            i_rdata2      = rf[i_raddr2];
            #1;
            n_checks++; if (o_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, o_ready, mq.size() < 2); end
            ev = (mq.size() > 0 && !i_hold && mq[0].rw && mq[0].a != 0) ? 32'd1 : 32'd0;
            n_checks++; if (o_we !== ev[0]) begin n_fail++; $display("FAIL rnd_we c=%0d got %b exp %b", c, o_we, ev[0]); end
            n_checks++;
            if (mq.size() > 0 ? (o_waddr !== mq[0].a || o_wdata !== mq[0].d) : (o_waddr !== 5'd0 || o_wdata !== 32'd0)) begin
                n_fail++; $display("FAIL rnd_wport c=%0d got %h/%h exp %h/%h", c, o_waddr, o_wdata, mq.size() > 0 ? mq[0].a : 5'd0, mq.size() > 0 ? mq[0].d : 32'd0);
            end
            ev = ref_byp(i_raddr1, i_rdata1);
            n_checks++; if (o_rdata1 !== ev) begin n_fail++; $display("FAIL rnd_byp1 c=%0d got %h exp %h", c, o_rdata1, ev); end
            ev = ref_byp(i_raddr2, i_rdata2);
            n_checks++; if (o_rdata2 !== ev) begin n_fail++; $display("FAIL rnd_byp2 c=%0d got %h exp %h", c, o_rdata2, ev); end
            n_checks++; if (o_retired !== exp_ret) begin n_fail++; $display("FAIL rnd_retired c=%0d got %h exp %h", c, o_retired, exp_ret); end
            push = i_valid && mq.size() < 2;
            pop  = mq.size() > 0 && !i_hold;
            e.rw = i_regwrite; e.a = i_waddr;
            e.d  = ref_fmt(i_mem_data, i_ld_size, i_ld_unsigned, i_byte_off, i_mem_to_reg, i_alu_res);
            @(posedge i_clk);
            if (pop) begin
                if (mq[0].rw && mq[0].a != 0) rf[mq[0].a] = mq[0].d;
                exp_ret++;
                void'(mq.pop_front());
            end
            if (push) mq.push_back(e);
            @(negedge i_clk);
        end
    endtask

    initial begin
        exp_ret = 0;
        test_reset();
        test_load_format();
        test_zero_write();
        test_back_to_back();
        test_stream();
        test_wrap();
        idle_inputs();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
